// File: rtl/multdiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Iteration counter must hold WIDTH; never narrower than six bits.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width + 1);
        return (w < 6) ? 6 : w;
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t                op,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] pr_s;
    logic [WIDTH:0] diff_s;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        sum_s  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        pr_s   = acc[2*WIDTH-1:WIDTH-1];
        diff_s = pr_s - {1'b0, opd};
        if (op == OP_MULT) begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end else if (!diff_s[WIDTH]) begin
            acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {pr_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiply/divide with busy/start handshake;
// WIDTH+2 edges per operation including the sign-fix and done cycles.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_resultHi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZEROS   = {WIDTH{1'b0}};

    state_t             state_r;
    state_t             state_s;
    logic               start_s;
    op_t                op_r;
    logic               sgn_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   opd_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_s;

    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   lo_s;
    logic [WIDTH-1:0]   hi_s;
    logic               exc_s;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_r),
        .acc      (acc_r),
        .opd      (opd_r),
        .acc_next (acc_s)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    start_s = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Operand magnitudes for signed mode; MIN maps to itself as an unsigned magnitude
    always_comb begin
        if (ctrl_signed && data_operandA[WIDTH-1]) begin
            a_mag_s = -data_operandA;
        end else begin
            a_mag_s = data_operandA;
        end
        if (ctrl_signed && data_operandB[WIDTH-1]) begin
            b_mag_s = -data_operandB;
        end else begin
            b_mag_s = data_operandB;
        end
    end

    // Sign correction and exception detection applied on the FIX edge
    always_comb begin
        prod_s = neg_lo_r ? -acc_r : acc_r;
        quo_s  = neg_lo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        rem_s  = neg_hi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        lo_s   = ZEROS;
        hi_s   = ZEROS;
        exc_s  = 1'b0;
        if (op_r == OP_MULT) begin
            lo_s = prod_s[WIDTH-1:0];
            hi_s = prod_s[2*WIDTH-1:WIDTH];
            if (sgn_r) begin
                exc_s = (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
                        (prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
            end else begin
                exc_s = (prod_s[2*WIDTH-1:WIDTH] != ZEROS);
            end
        end else if (b_r == ZEROS) begin
            lo_s  = ZEROS;
            hi_s  = a_r;
            exc_s = 1'b1;
        end else if (sgn_r && (a_r == MIN_VAL) && (b_r == ONES)) begin
            lo_s  = MIN_VAL;
            hi_s  = ZEROS;
            exc_s = 1'b1;
        end else begin
            lo_s  = quo_s;
            hi_s  = rem_s;
            exc_s = 1'b0;
        end
    end

    // Operand capture, iteration, and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_r           <= OP_MULT;
            sgn_r          <= 1'b0;
            neg_lo_r       <= 1'b0;
            neg_hi_r       <= 1'b0;
            cnt_r          <= {CW{1'b0}};
            a_r            <= ZEROS;
            b_r            <= ZEROS;
            opd_r          <= ZEROS;
            acc_r          <= {(2*WIDTH){1'b0}};
            data_result    <= ZEROS;
            data_resultHi  <= ZEROS;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start_s) begin
                        op_r     <= ctrl_MULT ? OP_MULT : OP_DIV;
                        sgn_r    <= ctrl_signed;
                        neg_lo_r <= ctrl_signed && (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
                        neg_hi_r <= ctrl_signed && data_operandA[WIDTH-1];
                        a_r      <= data_operandA;
                        b_r      <= data_operandB;
                        opd_r    <= ctrl_MULT ? a_mag_s : b_mag_s;
                        acc_r    <= {ZEROS, (ctrl_MULT ? b_mag_s : a_mag_s)};
                        cnt_r    <= {CW{1'b0}};
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r <= acc_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    data_result    <= lo_s;
                    data_resultHi  <= hi_s;
                    data_exception <= exc_s;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: driver pushes reference results,
// a negedge monitor pops and compares whenever data_resultRDY is high.
module tb_multdiv_iter;

    localparam int W = 32;

    logic          clock;
    logic          reset_n;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic          ctrl_MULT;
    logic          ctrl_DIV;
    logic          ctrl_signed;
    logic [W-1:0]  data_result;
    logic [W-1:0]  data_resultHi;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         exc;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   failures;

    multdiv_iter #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_signed    (ctrl_signed),
        .data_result    (data_result),
        .data_resultHi  (data_resultHi),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endfunction

    // Reference model: plain integer arithmetic on the specified rules
    function automatic exp_t model(input bit mul, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        r;
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sbv;
        r.cyc  = 0;
        r.name = "";
        if (mul) begin
            if (sgn) begin
                sp    = longint'($signed(a)) * longint'($signed(b));
                up    = sp;
                r.lo  = up[31:0];
                r.hi  = up[63:32];
                r.exc = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            end else begin
                up    = {32'h0, a} * {32'h0, b};
                r.lo  = up[31:0];
                r.hi  = up[63:32];
                r.exc = (up[63:32] != 32'h0);
            end
        end else if (b == 32'h0) begin
            r.lo = 32'h0; r.hi = a; r.exc = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000; r.hi = 32'h0; r.exc = 1'b1;
        end else if (sgn) begin
            sa   = $signed(a);
            sbv  = $signed(b);
            r.lo = sa / sbv;
            r.hi = sa % sbv;
            r.exc = 1'b0;
        end else begin
            r.lo = a / b; r.hi = a % b; r.exc = 1'b0;
        end
        return r;
    endfunction

    // Called at negedge+1 with the DUT idle or in its done cycle
    task automatic issue(input string n, input bit mul, input bit div, input bit sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        ctrl_signed   = sgn;
        e      = model(mul, sgn, a, b);
        e.cyc  = cyc + 1 + W + 1;
        e.name = n;
        sb.push_back(e);
        @(negedge clock); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_signed   = 1'($urandom_range(0, 1));
        chk({n, "_busy"}, {63'h0, busy}, 64'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * W && sb.size() != 0; i++) begin
            @(negedge clock); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: each RDY pulse must match the oldest expected result and its cycle
    always @(negedge clock) begin : mon
        exp_t e;
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy cycle=%0d got=1 want=0", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_lo"},  {32'h0, data_result},     {32'h0, e.lo});
                chk({e.name, "_hi"},  {32'h0, data_resultHi},   {32'h0, e.hi});
                chk({e.name, "_exc"}, {63'h0, data_exception},  {63'h0, e.exc});
                chk({e.name, "_cyc"}, 64'(cyc),                 64'(e.cyc));
                chk({e.name, "_busy_done"}, {63'h0, busy},      64'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        ctrl_signed = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_lo",   {32'h0, data_result},    64'h0);
        chk("rst_hi",   {32'h0, data_resultHi},  64'h0);
        chk("rst_exc",  {63'h0, data_exception}, 64'h0);
        chk("rst_rdy",  {63'h0, data_resultRDY}, 64'h0);
        chk("rst_busy", {63'h0, busy},           64'h0);
        reset_n = 1'b1;
        @(negedge clock); #1;

        issue("smul_7x-3", 1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD);
        drain();
        @(negedge clock); #1;
        issue("umul_ovf", 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
        drain();
        issue("smul_ovf", 1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000);
        drain();
        issue("sdiv_-7/2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        drain();
        issue("div_by_0", 1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        drain();
        issue("sdiv_min", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        issue("both_high", 1'b1, 1'b1, 1'b0, 32'd1000, 32'd7);
        drain();

        // DIV pulse at edge 10 of a running MULT must be ignored
        repeat (2) @(negedge clock);
        #1;
        issue("mul_ignore", 1'b1, 1'b0, 1'b0, 32'd123456, 32'd789);
        repeat (8) begin
            @(negedge clock); #1;
        end
        data_operandA = 32'd99;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(negedge clock); #1;
        ctrl_DIV = 1'b0;
        chk("ignore_busy", {63'h0, busy}, 64'h1);
        drain();

        for (int i = 0; i < 40; i++) begin
            logic        m;
            logic        s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            m = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            issue($sformatf("rnd%0d", i), m, ~m, s, a, b);
            drain();
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock); #1;
            end
        end

        // Reset at edge 15 of a DIV aborts it without an RDY pulse
        @(negedge clock); #1;
        data_operandA = 32'd1000;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        ctrl_signed = 1'b0;
        @(negedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (13) begin
            @(negedge clock); #1;
        end
        reset_n = 1'b0;
        @(negedge clock); #1;
        chk("abort_busy", {63'h0, busy},           64'h0);
        chk("abort_lo",   {32'h0, data_result},    64'h0);
        chk("abort_hi",   {32'h0, data_resultHi},  64'h0);
        chk("abort_exc",  {63'h0, data_exception}, 64'h0);
        chk("abort_rdy",  {63'h0, data_resultRDY}, 64'h0);
        reset_n = 1'b1;
        repeat (W + 8) begin
            @(negedge clock); #1;
        end
        issue("mul_3x4", 1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        drain();
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Parametrised iterative multiply/divide unit. Successor to the fixed 32-bit mult/div pair.
- Adds WIDTH generalisation, per-operation signed/unsigned mode, a busy/start handshake, high-half/remainder output, defined overflow and divide-by-zero exceptions, and synchronous reset abort.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and captures results on data_resultRDY.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be at least 4.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled on the start edge only.
- data_operandB  in  WIDTH  multiplier / divisor; sampled on the start edge only.
- ctrl_MULT  in  1  start a multiply; level sampled on the edge.
- ctrl_DIV  in  1  start a divide; level sampled on the edge.
- ctrl_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on the start edge.
- data_result  out  WIDTH  low product, or quotient.
- data_resultHi  out  WIDTH  high product half, or remainder.
- data_exception  out  1  overflow or divide-by-zero for the completed operation.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  operation in flight; start requests are ignored while high.

Behaviour:
- Reset (reset_n=0 at an edge) forces state IDLE and clears all outputs: data_result=0, data_resultHi=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset mid-operation aborts the operation. No RDY pulse is produced for it.

State machine:
- States: IDLE, RUN, FIX, DONE.
- IDLE: a start is accepted when ctrl_MULT|ctrl_DIV is high at an edge (edge 0).
  - If both are high, MULT wins.
  - On acceptance: latch operands, op and signed mode; busy=1 from edge 0; next state RUN.
  - Signed mode converts operands to magnitudes and records the result signs.
- RUN: exactly WIDTH edges (edges 1..WIDTH). 6-bit-min counter sized clog2(WIDTH+1).
  - MULT: radix-2 shift-add, one multiplier bit per edge, into a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract, one quotient bit per edge.
- FIX (edge WIDTH+1): apply sign correction, compute the exception, load the output registers, set data_resultRDY=1 and busy=0. Next state DONE.
- DONE: data_resultRDY is high for exactly this one cycle. The next edge clears it and returns to IDLE.
  - A start present on that edge is accepted: back-to-back throughput is one op per WIDTH+2 edges.
- Outputs hold their values after RDY until the FIX of the next operation.
- ctrl_MULT/ctrl_DIV and operand changes while busy=1 are ignored.

Arithmetic rules:
- MULT: {data_resultHi,data_result} = full 2*WIDTH product, signed or unsigned per mode.
  - Exception (unsigned): high half ≠ 0.
  - Exception (signed): bits [2W-1:W-1] are not all equal.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: quotient=0, remainder=A, exception=1. Same latency as a normal divide (no early out).
- Signed MIN/-1: quotient=MIN, remainder=0, exception=1.
- data_exception is 0 for all other results.

Decomposition:
- Package multdiv_pkg holds: state encoding (IDLE/RUN/FIX/DONE), op encoding (OP_MULT, OP_DIV), and the function for counter width from WIDTH.
- Sub-module multdiv_step: combinational one-iteration datapath (add-or-pass for MULT, subtract-and-restore for DIV), parametrised by WIDTH.
- FSM, counter and sign handling stay in the top module.

Test Plan:
- WIDTH=32, signed MULT 7 × -3:
  - RDY high exactly after edge 33 for one cycle.
  - result=0xFFFFFFEB, resultHi=0xFFFFFFFF, exception=0.
- Unsigned MULT 0x00010000 × 0x00010000: result=0, resultHi=1, exception=1. Same operands with ctrl_signed=1 also give exception=1.
- Signed DIV -7 / 2: result=0xFFFFFFFD (-3), resultHi=0xFFFFFFFF (-1), exception=0.
- DIV 5 / 0: result=0, resultHi=5, exception=1, latency unchanged. Signed 0x80000000 / 0xFFFFFFFF: result=0x80000000, resultHi=0, exception=1.
- Handshake:
  - ctrl_DIV pulsed at edge 10 of a running MULT is ignored; MULT result is unaltered.
  - ctrl_MULT and ctrl_DIV both high in IDLE runs a MULT.
  - A start held during the DONE cycle starts the next op; its RDY follows WIDTH+2 edges later.
- reset_n low at edge 15 of a DIV: the next cycle has busy=0 and all outputs 0, and no RDY pulse follows. A new MULT 3×4 then gives 12.
